// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz) and the phase encoding
// used by both the horizontal and vertical axis counters.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam bit SYNC_POL = 1'b0;
    localparam int CW       = 10;

    // One encoding serves both axes: active, front porch, sync pulse, back porch.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SP  = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus phase FSM. The sync level and the
// active flag are derived from the next-state phase so they line up with count_o.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   CW       = 10,
    parameter int   ACTIVE   = 640,
    parameter int   FRONT    = 16,
    parameter int   SYNC     = 96,
    parameter int   BACK     = 48,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic          sync_o,
    output logic          active_d_o,
    output logic          wrap_o
);

    localparam logic [CW-1:0] FP_START = CW'(ACTIVE);
    localparam logic [CW-1:0] SP_START = CW'(ACTIVE + FRONT);
    localparam logic [CW-1:0] BP_START = CW'(ACTIVE + FRONT + SYNC);
    localparam logic [CW-1:0] LAST     = CW'(ACTIVE + FRONT + SYNC + BACK - 1);

    logic [CW-1:0] count_q, count_d;
    phase_e        phase_q, phase_d;
    logic          sync_q, sync_d;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (inc_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
            if (count_d == '0) begin
                phase_d = PH_ACT;
            end else if (count_d == FP_START) begin
                phase_d = PH_FP;
            end else if (count_d == SP_START) begin
                phase_d = PH_SP;
            end else if (count_d == BP_START) begin
                phase_d = PH_BP;
            end
        end
        sync_d = (phase_d == PH_SP) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            phase_q <= PH_ACT;
            sync_q  <= ~SYNC_POL;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o    = count_q;
    assign sync_o     = sync_q;
    assign active_d_o = (phase_d == PH_ACT);
    assign wrap_o     = (count_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator advancing one pixel per pix_en strobe; the
// vertical axis steps only on an enabled horizontal wrap.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK   = vga_timing_pkg::H_BACK,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK   = vga_timing_pkg::V_BACK,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL,
    parameter int   CW       = vga_timing_pkg::CW
) (
    input  logic          InputClock,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          frame_start
);

    logic hWrap, vWrap, hActD, vActD, vInc;
    logic video_on_q, frame_start_q;

    assign vInc = pix_en & hWrap;

    vga_axis_counter #(
        .CW(CW), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .SYNC_POL(SYNC_POL)
    ) u_h (
        .clk_i(InputClock), .rst_i(rst), .inc_i(pix_en),
        .count_o(hcount), .sync_o(hsync), .active_d_o(hActD), .wrap_o(hWrap)
    );

    vga_axis_counter #(
        .CW(CW), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .SYNC_POL(SYNC_POL)
    ) u_v (
        .clk_i(InputClock), .rst_i(rst), .inc_i(vInc),
        .count_o(vcount), .sync_o(vsync), .active_d_o(vActD), .wrap_o(vWrap)
    );

    // video_on stays low out of reset until the first enabled pixel.
    always_ff @(posedge InputClock or posedge rst) begin
        if (rst) begin
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= vInc & vWrap;
            if (pix_en) begin
                video_on_q <= hActD & vActD;
            end
        end
    end

    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen; the vertical timing is shrunk to a
// 15-line frame so whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int HT  = 800;
    localparam int VA  = 8;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int VT  = VA + VF + VS + VB;

    logic       InputClock = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] hcount, vcount;
    logic       hsync, vsync, video_on, frame_start;

    int   checks = 0;
    int   errors = 0;
    int   mh, mv;
    logic mfs, mLive;

    typedef struct {
        logic r;
        logic e;
        int   n;
        int   eh;
        int   ev;
        logic ehs;
        logic evs;
        logic evo;
        logic efs;
    } vec_t;

    vec_t vecs[11];

    vga_sync_gen #(
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .InputClock(InputClock), .rst(rst), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .frame_start(frame_start)
    );

    always #5 InputClock = ~InputClock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mh = 0; mv = 0; mfs = 1'b0; mLive = 1'b0;
    endtask

    task automatic modelEdge(input logic r, input logic e);
        if (r) begin
            modelReset();
        end else if (e) begin
            mfs   = (mh == HT - 1) && (mv == VT - 1);
            mLive = 1'b1;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            mfs = 1'b0;
        end
    endtask

    function automatic logic expHs();
        return (mh >= 656 && mh <= 751) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic expVs();
        return (mv >= VA + VF && mv <= VA + VF + VS - 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic expVo();
        return mLive && (mh < 640) && (mv < VA);
    endfunction

    task automatic applyStimulus(input logic r, input logic e);
        rst    = r;
        pix_en = e;
        @(posedge InputClock);
        modelEdge(r, e);
        #1;
    endtask

    task automatic runTo(input int th, input int tv);
        int n = 0;
        while (!(mh == th && mv == tv) && n < HT * VT + 5) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        checkOutput($sformatf("reach_h_%0d_%0d", th, tv), hcount, th);
        checkOutput($sformatf("reach_v_%0d_%0d", th, tv), vcount, tv);
    endtask

    task automatic checkVec(input string nm, input int eh, input int ev,
                            input logic ehs, input logic evs, input logic evo, input logic efs);
        checkOutput({nm, "_hcount"}, hcount, eh);
        checkOutput({nm, "_vcount"}, vcount, ev);
        checkOutput({nm, "_hsync"}, hsync, ehs);
        checkOutput({nm, "_vsync"}, vsync, evs);
        checkOutput({nm, "_video_on"}, video_on, evo);
        checkOutput({nm, "_frame_start"}, frame_start, efs);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   scanDiff, ticks, lastTick, interval;
        logic scanEn;

        rst    = 1'b1;
        pix_en = 1'b0;
        modelReset();

        // {rst, pix_en, cycles, hcount, vcount, hsync, vsync, video_on, frame_start}
        vecs[0]  = '{1'b1, 1'b1, 2,   0,   0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 638, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1,   640, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 15,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1,   656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 95,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1,   752, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 47,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            repeat (vecs[i].n) applyStimulus(vecs[i].r, vecs[i].e);
            checkVec($sformatf("vec%0d", i), vecs[i].eh, vecs[i].ev,
                     vecs[i].ehs, vecs[i].evs, vecs[i].evo, vecs[i].efs);
        end

        // Enable every second cycle: 800 pixels take 1600 clocks.
        for (int i = 0; i < 1600; i++) applyStimulus(1'b0, (i % 2) == 0);
        checkOutput("gate_hcount", hcount, 0);
        checkOutput("gate_vcount", vcount, 2);

        scanDiff = 0; ticks = 0; lastTick = -1; interval = -1;
        for (int i = 0; i < 40000; i++) begin
            scanEn = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b0, scanEn);
            if (scanEn) ticks++;
            if (frame_start === 1'b1) begin
                if (lastTick >= 0 && interval < 0) interval = ticks - lastTick;
                lastTick = ticks;
            end
            if (hcount !== mh[9:0] || vcount !== mv[9:0] || hsync !== expHs() ||
                vsync !== expVs() || video_on !== expVo() || frame_start !== mfs) begin
                scanDiff++;
                if (scanDiff == 1)
                    $display("[TB] first scan difference at model (%0d,%0d): dut (%0d,%0d) hs %b vs %b vo %b fs %b",
                             mh, mv, hcount, vcount, hsync, vsync, video_on, frame_start);
            end
        end
        checkOutput("scan_diffs", scanDiff, 0);
        checkOutput("frame_interval", interval, HT * VT);

        runTo(799, VT - 1);
        checkOutput("prewrap_fs", frame_start, 0);
        applyStimulus(1'b0, 1'b1);
        checkVec("wrap", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkVec("wrap_hold", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkVec("wrap_next", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);

        runTo(655, VA + VF - 1);
        repeat (50) applyStimulus(1'b0, 1'b0);
        checkVec("hold", 655, 9, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkVec("hold_next", 656, 9, 1'b0, 1'b1, 1'b0, 1'b0);

        runTo(799, 9);
        applyStimulus(1'b0, 1'b1);
        checkVec("vsync_on", 0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        runTo(799, 11);
        applyStimulus(1'b0, 1'b1);
        checkVec("vsync_off", 0, 12, 1'b1, 1'b1, 1'b0, 1'b0);
        runTo(799, VA - 1);
        applyStimulus(1'b0, 1'b1);
        checkVec("vact_end", 0, 8, 1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-line, inside the vertical sync pulse.
        runTo(300, 10);
        checkOutput("prerst_vsync", vsync, 0);
        rst = 1'b1;
        #2;
        checkVec("async_rst", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        modelReset();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkVec("post_rst", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
